// File: rtl/alu_exec_unit_if.sv
// Handshake bundle between the ID/EX register side (master) and alu_exec_unit (slave).
interface alu_exec_unit_if #(
   parameter int unsigned XLEN = 32
) ();
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      alu_ctrl;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            br_cond;
   logic            illegal;

   modport master (
      output in_valid, alu_ctrl, op_a, op_b, out_ready,
      input  in_ready, out_valid, result, br_cond, illegal
   );

   modport slave (
      input  in_valid, alu_ctrl, op_a, op_b, out_ready,
      output in_ready, out_valid, result, br_cond, illegal
   );
endinterface

// File: rtl/alu_exec_unit.sv
// EX-stage ALU with valid/ready handshake, registered result and branch flag.
// Define ALU_FAST_SHIFT_EN for a single-cycle barrel shifter instead of the iterative one.
`ifndef ADD
`define ADD   4'b0000
`define SLL   4'b0001
`define SLT   4'b0010
`define SLTU  4'b0011
`define XOR   4'b0100
`define SRL   4'b0101
`define OR    4'b0110
`define AND   4'b0111
`define SUB   4'b1000
`define NOTEQ 4'b1001
`define SGE   4'b1010
`define SGEU  4'b1011
`define JUMP  4'b1100
`define SRA   4'b1101
`endif

module alu_exec_unit #(
   parameter int unsigned XLEN = 32
) (
   input logic            clk,
   input logic            rstn,
   input logic            flush,
   alu_exec_unit_if.slave bus
);
   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            br_q, br_d;
   logic            ill_q, ill_d;
   logic [XLEN-1:0] alu_res;
   logic            alu_br, alu_ill;
   logic            lt_s, lt_u;
   logic [4:0]      shamt;

   assign shamt = bus.op_b[4:0];
   assign lt_s  = $signed(bus.op_a) < $signed(bus.op_b);
   assign lt_u  = bus.op_a < bus.op_b;

   // Single-cycle datapath, evaluated on the operands presented in IDLE.
   always_comb begin
      alu_res = '0;
      alu_ill = 1'b0;
      case (bus.alu_ctrl)
         `ADD:   alu_res = bus.op_a + bus.op_b;
         `SUB:   alu_res = bus.op_a - bus.op_b;
         `XOR:   alu_res = bus.op_a ^ bus.op_b;
         `OR:    alu_res = bus.op_a | bus.op_b;
         `AND:   alu_res = bus.op_a & bus.op_b;
         `SLT:   alu_res = {{(XLEN-1){1'b0}}, lt_s};
         `SLTU:  alu_res = {{(XLEN-1){1'b0}}, lt_u};
         `SGE:   alu_res = {{(XLEN-1){1'b0}}, ~lt_s};
         `SGEU:  alu_res = {{(XLEN-1){1'b0}}, ~lt_u};
         `NOTEQ: alu_res = {{(XLEN-1){1'b0}}, (bus.op_a != bus.op_b)};
         `JUMP:  alu_res = bus.op_a + XLEN'(4);
`ifdef ALU_FAST_SHIFT_EN
         `SLL:   alu_res = bus.op_a << shamt;
         `SRL:   alu_res = bus.op_a >> shamt;
         `SRA:   alu_res = $unsigned($signed(bus.op_a) >>> shamt);
`else
         // Only reached with shamt == 0; nonzero amounts go through StShift.
         `SLL, `SRL, `SRA: alu_res = bus.op_a;
`endif
         default: alu_ill = 1'b1;
      endcase
   end

   always_comb begin
      case (bus.alu_ctrl)
         `SUB:                             alu_br = (alu_res == '0);
         `NOTEQ, `SLT, `SGE, `SLTU, `SGEU: alu_br = alu_res[0];
         default:                          alu_br = 1'b0;
      endcase
   end

`ifndef ALU_FAST_SHIFT_EN
   logic [XLEN-1:0] work_q, work_d, work_step;
   logic [4:0]      cnt_q, cnt_d;
   logic [3:0]      sop_q, sop_d;
   logic            is_shift;

   assign is_shift = (bus.alu_ctrl == `SLL) || (bus.alu_ctrl == `SRL) ||
                     (bus.alu_ctrl == `SRA);

   always_comb begin
      case (sop_q)
         `SLL:    work_step = work_q << 1;
         `SRA:    work_step = {work_q[XLEN-1], work_q[XLEN-1:1]};
         default: work_step = work_q >> 1;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         work_q <= '0;
         cnt_q  <= '0;
         sop_q  <= '0;
      end else begin
         work_q <= work_d;
         cnt_q  <= cnt_d;
         sop_q  <= sop_d;
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      br_d     = br_q;
      ill_d    = ill_q;
`ifndef ALU_FAST_SHIFT_EN
      work_d   = work_q;
      cnt_d    = cnt_q;
      sop_d    = sop_q;
`endif
      if (flush) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.in_valid) begin
`ifndef ALU_FAST_SHIFT_EN
                  if (is_shift && (shamt != 5'd0)) begin
                     work_d  = bus.op_a;
                     cnt_d   = shamt;
                     sop_d   = bus.alu_ctrl;
                     state_d = StShift;
                  end else begin
`else
                  begin
`endif
                     result_d = alu_res;
                     br_d     = alu_br;
                     ill_d    = alu_ill;
                     state_d  = StDone;
                  end
               end
            end
`ifndef ALU_FAST_SHIFT_EN
            StShift: begin
               work_d = work_step;
               cnt_d  = cnt_q - 5'd1;
               if (cnt_q == 5'd1) begin
                  result_d = work_step;
                  br_d     = 1'b0;
                  ill_d    = 1'b0;
                  state_d  = StDone;
               end
            end
`endif
            StDone: begin
               if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= StIdle;
         result_q <= '0;
         br_q     <= 1'b0;
         ill_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         br_q     <= br_d;
         ill_q    <= ill_d;
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.result    = result_q;
   assign bus.br_cond   = br_q;
   assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases plus randomized ops vs a model.
`ifndef ADD
`define ADD   4'b0000
`define SLL   4'b0001
`define SLT   4'b0010
`define SLTU  4'b0011
`define XOR   4'b0100
`define SRL   4'b0101
`define OR    4'b0110
`define AND   4'b0111
`define SUB   4'b1000
`define NOTEQ 4'b1001
`define SGE   4'b1010
`define SGEU  4'b1011
`define JUMP  4'b1100
`define SRA   4'b1101
`endif

module tb_alu_exec_unit;
   logic clk   = 1'b0;
   logic rstn  = 1'b1;
   logic flush = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

`ifdef ALU_FAST_SHIFT_EN
   localparam bit FastShift = 1'b1;
`else
   localparam bit FastShift = 1'b0;
`endif

   typedef struct {
      logic [3:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        br;
      logic        ill;
      int          lat;
   } vec_t;

   alu_exec_unit_if #(.XLEN(32)) bus ();

   alu_exec_unit #(.XLEN(32)) dut (
      .clk   (clk),
      .rstn  (rstn),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1);
   end

   // Reference model straight from the operation table; latency counts accept edge.
   function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic br, output logic ill,
                                 output int lat);
      int s;
      s   = int'(b[4:0]);
      r   = 32'd0;
      ill = 1'b0;
      lat = 1;
      case (c)
         `ADD:   r = a + b;
         `SUB:   r = a - b;
         `XOR:   r = a ^ b;
         `OR:    r = a | b;
         `AND:   r = a & b;
         `SLL:   r = a << s;
         `SRL:   r = a >> s;
         `SRA:   r = $unsigned($signed(a) >>> s);
         `SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         `SLTU:  r = (a < b) ? 32'd1 : 32'd0;
         `SGE:   r = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
         `SGEU:  r = (a >= b) ? 32'd1 : 32'd0;
         `NOTEQ: r = (a != b) ? 32'd1 : 32'd0;
         `JUMP:  r = a + 32'd4;
         default: ill = 1'b1;
      endcase
      if (c == `SUB) br = (r == 32'd0);
      else if (c == `NOTEQ || c == `SLT || c == `SGE || c == `SLTU || c == `SGEU) br = r[0];
      else br = 1'b0;
      if (!FastShift && (c == `SLL || c == `SRL || c == `SRA) && s != 0) lat = 1 + s;
   endfunction

   // Presents one op from a negedge in IDLE; returns at the negedge where out_valid is seen.
   task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic br, output logic ill, output int lat);
      bus.alu_ctrl = c;
      bus.op_a     = a;
      bus.op_b     = b;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      lat = 1;
      while (!bus.out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!bus.out_valid) lat = 99;
      r   = bus.result;
      br  = bus.br_cond;
      ill = bus.illegal;
   endtask

   task automatic release_out();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1 rstn = 1'b0;
      repeat (2) @(negedge clk);
      n_checks += 5;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
      end
      if (bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
      end
      if (bus.result !== 32'd0) begin
         n_fail++; $display("FAIL reset_result: got %h expected 0", bus.result);
      end
      if (bus.br_cond !== 1'b0) begin
         n_fail++; $display("FAIL reset_br_cond: got %b expected 0", bus.br_cond);
      end
      if (bus.illegal !== 1'b0) begin
         n_fail++; $display("FAIL reset_illegal: got %b expected 0", bus.illegal);
      end
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      vec_t        tbl [11];
      logic [31:0] r;
      logic        br, ill;
      int          lat;
      tbl[0]  = '{`ADD,   32'hFFFF_FFFF, 32'd1,  32'h0,         1'b0, 1'b0, 1};
      tbl[1]  = '{`SUB,   32'd5,         32'd5,  32'h0,         1'b1, 1'b0, 1};
      tbl[2]  = '{`NOTEQ, 32'd5,         32'd6,  32'h1,         1'b1, 1'b0, 1};
      tbl[3]  = '{`SLT,   32'h8000_0000, 32'd1,  32'h1,         1'b1, 1'b0, 1};
      tbl[4]  = '{`SLTU,  32'h8000_0000, 32'd1,  32'h0,         1'b0, 1'b0, 1};
      tbl[5]  = '{`SGE,   32'h8000_0000, 32'd1,  32'h0,         1'b0, 1'b0, 1};
      tbl[6]  = '{`SGEU,  32'h8000_0000, 32'd1,  32'h1,         1'b1, 1'b0, 1};
      tbl[7]  = '{`SRA,   32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, FastShift ? 1 : 32};
      tbl[8]  = '{`SLL,   32'h1234_5678, 32'd0,  32'h1234_5678, 1'b0, 1'b0, 1};
      tbl[9]  = '{4'b1111, 32'h55,       32'h66, 32'h0,         1'b0, 1'b1, 1};
      tbl[10] = '{4'b1110, 32'h77,       32'h88, 32'h0,         1'b0, 1'b1, 1};
      for (int i = 0; i < 11; i++) begin
         do_op(tbl[i].c, tbl[i].a, tbl[i].b, r, br, ill, lat);
         n_checks += 4;
         if (r !== tbl[i].r) begin
            n_fail++; $display("FAIL dir%0d_result: got %h expected %h", i, r, tbl[i].r);
         end
         if (br !== tbl[i].br) begin
            n_fail++; $display("FAIL dir%0d_br_cond: got %b expected %b", i, br, tbl[i].br);
         end
         if (ill !== tbl[i].ill) begin
            n_fail++; $display("FAIL dir%0d_illegal: got %b expected %b", i, ill, tbl[i].ill);
         end
         if (lat !== tbl[i].lat) begin
            n_fail++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, tbl[i].lat);
         end
         release_out();
         n_checks++;
         if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL dir%0d_handoff: got in_ready=%b out_valid=%b expected 1/0",
                     i, bus.in_ready, bus.out_valid);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] r;
      logic        br, ill;
      int          lat;
      do_op(`XOR, 32'hF0F0_F0F0, 32'hFFFF_0000, r, br, ill, lat);
      for (int i = 0; i < 6; i++) begin
         n_checks += 3;
         if (bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp%0d_out_valid: got %b expected 1", i, bus.out_valid);
         end
         if (bus.result !== 32'h0F0F_F0F0) begin
            n_fail++; $display("FAIL bp%0d_result: got %h expected 0f0ff0f0", i, bus.result);
         end
         if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp%0d_in_ready: got %b expected 0", i, bus.in_ready);
         end
         if (i < 5) @(negedge clk);
      end
      release_out();
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_release_in_ready: got %b expected 1", bus.in_ready);
      end
   endtask

   task automatic test_flush();
      logic [31:0] r;
      logic        br, ill;
      int          lat;
      int          seen;
      // In-flight SRL by 20 killed after ten cycles.
      bus.alu_ctrl = `SRL;
      bus.op_a     = 32'hDEAD_BEEF;
      bus.op_b     = 32'd20;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      n_checks += 3;
      if (seen !== (FastShift ? 9 : 0)) begin
         n_fail++;
         $display("FAIL flush_pre_valid: got %0d expected %0d", seen, FastShift ? 9 : 0);
      end
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL flush_in_ready: got %b expected 1", bus.in_ready);
      end
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         if (bus.out_valid) seen++;
         @(negedge clk);
      end
      if (seen !== 0) begin
         n_fail++; $display("FAIL flush_post_valid: got %0d cycles expected 0", seen);
      end
      // in_valid coincident with flush must be dropped.
      bus.alu_ctrl = `ADD;
      bus.in_valid = 1'b1;
      flush        = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_coincident: got in_ready=%b out_valid=%b expected 1/0",
                  bus.in_ready, bus.out_valid);
      end
      do_op(`JUMP, 32'h100, 32'h0, r, br, ill, lat);
      n_checks += 2;
      if (r !== 32'h104) begin
         n_fail++; $display("FAIL flush_jump_result: got %h expected 00000104", r);
      end
      if (lat !== 1) begin
         n_fail++; $display("FAIL flush_jump_latency: got %0d expected 1", lat);
      end
      release_out();
   endtask

   task automatic test_random();
      logic [31:0] a, b, r, er;
      logic [3:0]  c;
      logic        br, ill, ebr, eill;
      int          lat, elat;
      for (int i = 0; i < 150; i++) begin
         c = 4'($urandom_range(0, 15));
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) b = a;
         if ($urandom_range(0, 1) == 1) b[4:0] = 5'($urandom_range(0, 3));
         model(c, a, b, er, ebr, eill, elat);
         do_op(c, a, b, r, br, ill, lat);
         n_checks += 2;
         if (r !== er || br !== ebr || ill !== eill) begin
            n_fail++;
            $display("FAIL rand%0d_outputs: ctrl=%h a=%h b=%h got %h/%b/%b expected %h/%b/%b",
                     i, c, a, b, r, br, ill, er, ebr, eill);
         end
         if (lat !== elat) begin
            n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, lat, elat);
         end
         release_out();
      end
   endtask

   task automatic test_reset_mid_shift();
      bus.alu_ctrl = `SRA;
      bus.op_a     = 32'h8000_0000;
      bus.op_b     = 32'd31;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (5) @(negedge clk);
      n_checks += 2;
      if (bus.result !== (FastShift ? 32'hFFFF_FFFF : 32'h0000_0104)) begin
         n_fail++; $display("FAIL pre_reset_result: got %h", bus.result);
      end
      if (bus.in_ready !== 1'b0) begin
         n_fail++; $display("FAIL pre_reset_in_ready: got %b expected 0", bus.in_ready);
      end
      #2 rstn = 1'b0;
      #1;
      n_checks += 2;
      if (bus.out_valid !== 1'b0 || bus.result !== 32'd0 || bus.br_cond !== 1'b0 ||
          bus.illegal !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset_outputs: got v=%b r=%h br=%b ill=%b expected all 0",
                  bus.out_valid, bus.result, bus.br_cond, bus.illegal);
      end
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL async_reset_in_ready: got %b expected 1", bus.in_ready);
      end
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.alu_ctrl  = 4'd0;
      bus.op_a      = 32'd0;
      bus.op_b      = 32'd0;
      test_reset();
      test_directed();
      test_backpressure();
      test_flush();
      test_reset_mid_shift();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
